// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready byte handshake into the UART TX FIFO.
// The producer drives valid/data; the FIFO answers with ready.
interface uart_tx_fifo_if #(
    parameter int DATA_W = 8
);
    logic              inValid;
    logic [DATA_W-1:0] inData;
    logic              inReady;

    modport master (
        output inValid,
        output inData,
        input  inReady
    );

    modport slave (
        input  inValid,
        input  inData,
        output inReady
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding a Uart8 transmitter.
// One frame in flight; each byte is popped only once Uart8 acknowledges it.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ACK_TO = 4096
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   en,
    input  logic                   flush,
    uart_tx_fifo_if.slave          inBus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   txStart,
    output logic [DATA_W-1:0]      txIn,
    input  logic                   txBusy,
    input  logic                   txDone,
    output logic                   ackErr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (ACK_TO < 2) ? 1 : $clog2(ACK_TO);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] WAIT_ACK = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] GAP      = 3'd4;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic [2:0]        state;
    logic [CW-1:0]     ackCnt;
    logic              busyQ;
    logic              wrEn;
    logic              popEn;
    logic              ackTimeout;
    logic              busyFall;
    logic              notEmpty;

    assign inBus.inReady = (level != LW'(DEPTH));
    assign notEmpty      = (level != '0);
    assign wrEn          = inBus.inValid && inBus.inReady && !flush;
    assign popEn         = (state == WAIT_ACK) && txBusy && notEmpty && !flush;
    assign busyFall      = busyQ && !txBusy;
    // ACK_TO of zero disables the timeout entirely
    assign ackTimeout    = (ACK_TO != 0) && (ackCnt == CW'(ACK_TO - 1));

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= inBus.inData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (popEn) begin
                rdPtr <= rdPtr + AW'(1);
            end
            if (wrEn && !popEn) begin
                level <= level + LW'(1);
            end else if (popEn && !wrEn) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= IDLE;
            txStart <= 1'b0;
            txIn    <= '0;
            ackErr  <= 1'b0;
            ackCnt  <= '0;
            busyQ   <= 1'b0;
        end else begin
            ackErr <= 1'b0;
            busyQ  <= txBusy;
            case (state)
                IDLE: begin
                    txStart <= 1'b0;
                    ackCnt  <= '0;
                    if (en && notEmpty && !txBusy && !flush) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        txIn    <= mem[rdPtr];
                        txStart <= 1'b1;
                        ackCnt  <= '0;
                        state   <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (flush) begin
                        txStart <= 1'b0;
                        state   <= IDLE;
                    end else if (txBusy) begin
                        txStart <= 1'b0;
                        state   <= WAIT_DONE;
                    end else if (ackTimeout) begin
                        // byte stays at the head and is retried from IDLE
                        ackErr  <= 1'b1;
                        txStart <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        ackCnt <= ackCnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    txStart <= 1'b0;
                    if (txDone || busyFall) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    txStart <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    txStart <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
